// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings, widths
// and word-alignment constants.
package fetch_unit_pkg;

  localparam int INSTR_W    = 32;
  localparam int ALIGN_BITS = 2;
  localparam int WORD_BYTES = 1 << ALIGN_BITS;

  typedef enum logic [1:0] {
    FETCH_S_RESET = 2'd0,
    FETCH_S_REQ   = 2'd1,
    FETCH_S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_branch_target_calc.sv
// Branch target: issued_pc + 4 + (sign-extended word offset << 2), wrapping
// modulo 2^SIZE.
module branch_target_calc
  import fetch_unit_pkg::*;
#(
  parameter int SIZE     = INSTR_W,
  parameter int INM_SIZE = 16
) (
  input  logic [SIZE-1:0]     issued_pc,
  input  logic [INM_SIZE-1:0] branch_offset,
  output logic [SIZE-1:0]     target
);

  logic [SIZE-1:0] offset_bytes;

  assign offset_bytes = {{(SIZE-INM_SIZE-ALIGN_BITS){branch_offset[INM_SIZE-1]}},
                         branch_offset, {ALIGN_BITS{1'b0}}};

  assign target = issued_pc + SIZE'(WORD_BYTES) + offset_bytes;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, valid/ready presentation to decode,
// and branch redirect with wrong-path squash.
//
// state         | meaning
// FETCH_S_RESET | one idle cycle after reset, branch ignored
// FETCH_S_REQ   | imem_req high at req_addr, waiting for ack
// FETCH_S_HOLD  | instr valid, waiting for issue or branch
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              SIZE     = INSTR_W,
  parameter int              INM_SIZE = 16,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [SIZE-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [SIZE-1:0]     imem_data,
  output logic [SIZE-1:0]     instr,
  output logic [SIZE-1:0]     instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                branch_taken,
  input  logic [INM_SIZE-1:0] branch_offset
);

  localparam logic [SIZE-1:0] RESET_ADDR = {RESET_PC[SIZE-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

  fetch_state_t    state, state_next;
  logic [SIZE-1:0] pc;
  logic [SIZE-1:0] req_addr;
  logic [SIZE-1:0] issued_pc;
  logic [SIZE-1:0] target;
  logic [SIZE-1:0] redirect_addr;
  logic [SIZE-1:0] pc_inc;
  logic            squash;

  branch_target_calc #(
    .SIZE     (SIZE),
    .INM_SIZE (INM_SIZE)
  ) u_branch_target_calc (
    .issued_pc     (issued_pc),
    .branch_offset (branch_offset),
    .target        (target)
  );

  assign pc_inc = instr_pc + SIZE'(WORD_BYTES);

  // A squashed ack re-requests at the pending target unless a fresh branch overrides it.
  assign redirect_addr = branch_taken ? target : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_S_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_S_RESET: state_next = FETCH_S_REQ;
      FETCH_S_REQ: begin
        if (imem_ack && !squash && !branch_taken) begin
          state_next = FETCH_S_HOLD;
        end
      end
      FETCH_S_HOLD: begin
        if (branch_taken || instr_ready) begin
          state_next = FETCH_S_REQ;
        end
      end
      default: state_next = FETCH_S_RESET;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH_S_REQ);
    instr_valid = (state == FETCH_S_HOLD);
    imem_addr   = req_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_ADDR;
      req_addr  <= RESET_ADDR;
      issued_pc <= RESET_ADDR;
      squash    <= 1'b0;
      instr     <= '0;
      instr_pc  <= '0;
    end else begin
      case (state)
        FETCH_S_RESET: begin
          pc       <= RESET_ADDR;
          req_addr <= RESET_ADDR;
          squash   <= 1'b0;
        end
        FETCH_S_REQ: begin
          if (imem_ack) begin
            if (squash || branch_taken) begin
              pc       <= redirect_addr;
              req_addr <= redirect_addr;
              squash   <= 1'b0;
            end else begin
              instr    <= imem_data;
              instr_pc <= req_addr;
            end
          end else if (branch_taken) begin
            // Address stays stable on the bus; the in-flight word is dropped on ack.
            pc     <= target;
            squash <= 1'b1;
          end
        end
        FETCH_S_HOLD: begin
          if (branch_taken) begin
            pc       <= target;
            req_addr <= target;
          end else if (instr_ready) begin
            issued_pc <= instr_pc;
            pc        <= pc_inc;
            req_addr  <= pc_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, a transaction-level
// reference model compared every cycle, and literal expectations at key points.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  bit mem_auto = 1'b1;
  int mem_lat = 1;
  int mem_cnt = 0;
  logic [31:0] dut_issued[$];
  logic [31:0] mdl_issued[$];

  fetch_unit #(
    .SIZE     (32),
    .INM_SIZE (16),
    .RESET_PC (RPC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] branch_dest(input logic [31:0] from_pc, input logic [15:0] off);
    int o;
    o = int'($signed(off));
    return from_pc + 32'd4 + 32'(o * 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = post-reset idle, 1 = fetching, 2 = presenting.
  int          m_phase;
  logic [31:0] m_pc, m_fetch, m_issued, m_instr, m_ipc;
  bit          m_squash;
  logic [31:0] m_dest, m_redir;

  assign m_dest  = branch_dest(m_issued, branch_offset);
  assign m_redir = branch_taken ? m_dest : m_pc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  <= 0;
      m_pc     <= RPC;
      m_fetch  <= RPC;
      m_issued <= RPC;
      m_squash <= 1'b0;
      m_instr  <= '0;
      m_ipc    <= '0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
      m_pc    <= RPC;
      m_fetch <= RPC;
    end else if (m_phase == 1) begin
      if (imem_ack && (m_squash || branch_taken)) begin
        m_pc     <= m_redir;
        m_fetch  <= m_redir;
        m_squash <= 1'b0;
      end else if (imem_ack) begin
        m_instr <= imem_data;
        m_ipc   <= m_fetch;
        m_phase <= 2;
      end else if (branch_taken) begin
        m_pc     <= m_dest;
        m_squash <= 1'b1;
      end
    end else begin
      if (branch_taken) begin
        m_pc    <= m_dest;
        m_fetch <= m_dest;
        m_phase <= 1;
      end else if (instr_ready) begin
        mdl_issued.push_back(m_ipc);
        m_issued <= m_ipc;
        m_pc     <= m_ipc + 32'd4;
        m_fetch  <= m_ipc + 32'd4;
        m_phase  <= 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && instr_valid && instr_ready && !branch_taken) dut_issued.push_back(instr_pc);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_imem_req", imem_req, 32'(m_phase == 1));
      check("cyc_imem_addr", imem_addr, m_fetch);
      check("cyc_instr_valid", instr_valid, 32'(m_phase == 2));
      check("cyc_instr", instr, m_instr);
      check("cyc_instr_pc", instr_pc, m_ipc);
    end
  end

  // Memory responder: acks after mem_lat waiting cycles of an active request.
  task automatic mem_step();
    if (!mem_auto) return;
    if (reset) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end else begin
      if (imem_ack) mem_cnt = 0;
      if (imem_req && mem_cnt >= mem_lat) begin
        imem_ack  = 1'b1;
        imem_data = mem_word(imem_addr);
      end else begin
        imem_ack = 1'b0;
        if (imem_req) mem_cnt++;
        else mem_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_step();
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !instr_valid; i++) tick();
    n_checks++;
    if (!instr_valid) begin
      n_errors++;
      $display("FAIL timeout_valid_%s: instr_valid got 0 expected 1", tag);
    end
  endtask

  task automatic wait_issues(input int n, input string tag);
    for (int i = 0; i < 100 && dut_issued.size() < n; i++) tick();
    n_checks++;
    if (dut_issued.size() < n) begin
      n_errors++;
      $display("FAIL timeout_issue_%s: issued got %0d expected %0d", tag, dut_issued.size(), n);
    end
  endtask

  task automatic issue_one(input logic [31:0] exp_pc, input string tag);
    wait_valid(tag);
    check({"present_pc_", tag}, instr_pc, exp_pc);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check({"issued_pc_", tag}, dut_issued[$], exp_pc);
  endtask

  initial begin
    logic [31:0] h_instr, h_pc;
    bit acked;
    int n0;

    instr_ready = 1'b1;
    mem_lat = 1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (3) tick();
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 32'h100);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Sequential fetch after reset
    reset = 1'b0;
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h100);
    wait_issues(3, "seq");
    instr_ready = 1'b0;
    check("seq_pc0", dut_issued[0], 32'h100);
    check("seq_pc1", dut_issued[1], 32'h104);
    check("seq_pc2", dut_issued[2], 32'h108);
    check("model_pc0", mdl_issued[0], 32'h100);

    // Backpressure: hold five cycles, issue on the sixth
    wait_valid("hold");
    h_instr = instr;
    h_pc    = instr_pc;
    check("hold_pc", h_pc, 32'h10C);
    check("hold_instr", h_instr, mem_word(32'h10C));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_instr_stable", instr, h_instr);
      check("hold_pc_stable", instr_pc, h_pc);
      check("hold_no_req", imem_req, 0);
      check("hold_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("hold_issue_req", imem_req, 1);
    check("hold_issue_addr", imem_addr, 32'h110);

    // Branch in HOLD from issued 0x10C to 0x200
    wait_valid("br200");
    check("br200_held_pc", instr_pc, 32'h110);
    branch_taken  = 1'b1;
    branch_offset = 16'h003C;
    tick();
    branch_taken = 1'b0;
    check("br200_req", imem_req, 1);
    check("br200_addr", imem_addr, 32'h200);
    mem_lat = 3;
    issue_one(32'h200, "pc200");

    // Branch while the request at 0x204 waits for a slow ack
    check("sq_req", imem_req, 1);
    check("sq_addr0", imem_addr, 32'h204);
    branch_taken  = 1'b1;
    branch_offset = 16'h0010;
    tick();
    branch_taken = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      check("sq_addr_hold", imem_addr, 32'h204);
      check("sq_req_hold", imem_req, 1);
      if (imem_ack) acked = 1'b1;
      else tick();
    end
    n_checks++;
    if (!acked) begin
      n_errors++;
      $display("FAIL timeout_ack_sq: imem_ack got 0 expected 1");
    end
    tick();
    check("sq_next_addr", imem_addr, 32'h244);
    check("sq_next_req", imem_req, 1);
    check("sq_discard", instr_valid, 0);

    // Branch with ready also high: branch wins, held 0x244 never issues
    wait_valid("prio");
    check("prio_held_pc", instr_pc, 32'h244);
    mem_lat = 1;
    branch_taken  = 1'b1;
    branch_offset = 16'hFFFE;
    instr_ready   = 1'b1;
    tick();
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    check("prio_addr", imem_addr, 32'h1FC);
    check("prio_req", imem_req, 1);
    check("prio_issue_cnt", dut_issued.size(), 5);
    check("prio_last_issue", dut_issued[$], 32'h200);
    issue_one(32'h1FC, "pc1fc");

    // Wrap: branch to 0xFFFFFFFC, issue, next fetch at 0
    wait_valid("wrap");
    check("wrap_held_pc", instr_pc, 32'h200);
    branch_taken  = 1'b1;
    branch_offset = 16'hFF7F;
    tick();
    branch_taken = 1'b0;
    check("wrap_br_addr", imem_addr, 32'hFFFF_FFFC);
    issue_one(32'hFFFF_FFFC, "pcfffc");
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", imem_req, 1);

    // Reset while the request at 0 is outstanding, late ack afterwards
    mem_auto = 1'b0;
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", imem_req, 0);
    check("async_rst_addr", imem_addr, 32'h100);
    tick();
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_instr_pc", instr_pc, 0);
    reset         = 1'b0;
    imem_ack      = 1'b1;
    imem_data     = 32'hDEAD_BEEF;
    branch_taken  = 1'b1;
    branch_offset = 16'h0040;
    tick();
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    mem_auto     = 1'b1;
    mem_cnt      = 0;
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 32'h100);
    check("restart_valid", instr_valid, 0);
    check("restart_instr", instr, 0);
    n0 = dut_issued.size();
    instr_ready = 1'b1;
    wait_issues(n0 + 1, "restart");
    instr_ready = 1'b0;
    check("restart_issue_pc", dut_issued[$], 32'h100);
    check("restart_issue_instr", instr, mem_word(32'h100));
    repeat (4) tick();
    check("model_issue_total", mdl_issued.size(), 8);
    check("dut_issue_total", dut_issued.size(), mdl_issued.size());

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the ALU. It holds the program counter and requests instruction words from instruction memory over a req/ack handshake. Each fetched word is presented to decode/execute with a valid/ready handshake. It consumes the ALU's `branch_taken` decision, with the branch immediate, to redirect the PC and squash wrong-path fetches.

## Interface
Parameters:
- SIZE, 32, address and instruction data width
- INM_SIZE, 16, width of branch immediate (word offset)
- RESET_PC, 0, first fetch address; bits [1:0] forced to 0

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  instruction memory request
- imem_addr  output  SIZE  word-aligned request address, stable while imem_req high
- imem_ack  input  1  memory done; imem_data valid this cycle only
- imem_data  input  SIZE  instruction word
- instr  output  SIZE  instruction to decode
- instr_pc  output  SIZE  address of `instr`
- instr_valid  output  1  `instr`/`instr_pc` valid
- instr_ready  input  1  downstream accepts; issue = instr_valid & instr_ready
- branch_taken  input  1  ALU verdict for the most recently issued instruction
- branch_offset  input  INM_SIZE  that instruction's immediate, signed word offset

## Operation
- Registers: pc, req_addr, issued_pc (pc of last issued instr), squash flag, state.
- States: S_RESET -> S_REQ -> S_HOLD -> S_REQ ...
- S_RESET: entered on reset; leaves unconditionally next clock to S_REQ with pc=RESET_PC.
- S_REQ: imem_req=1, imem_addr=req_addr. On imem_ack: if squash or branch_taken this cycle, discard data, clear squash, stay S_REQ with new address; else latch instr=imem_data, instr_pc=req_addr, go S_HOLD.
- S_HOLD: instr_valid=1. On issue: issued_pc<=instr_pc, pc<=instr_pc+4, go S_REQ. instr/instr_pc stable until issue.
- Branch target = issued_pc + 4 + (sign_extend(branch_offset) << 2), modulo 2^SIZE.
- branch_taken in S_REQ without ack: pc<=target, squash<=1; req_addr unchanged until ack.
- branch_taken in S_HOLD: held instruction dropped (not issued even if instr_ready=1), pc<=target, go S_REQ. Branch has priority over issue.
- branch_taken in S_RESET: ignored.
- pc+4 and target wrap modulo 2^SIZE; bits [1:0] of every address always 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0; pc=RESET_PC, issued_pc=RESET_PC, squash=0, state=S_RESET.
- Reset mid-transaction: all state cleared immediately; outstanding ack after reset ignored.
- First imem_req: first clock edge after reset deassertion, plus 0 cycles (S_RESET lasts one cycle).
- Ack in cycle N -> instr_valid high in N+1.
- Issue in cycle M -> imem_req high at req_addr=pc in M+1.
- Branch in cycle B (S_HOLD) -> imem_req at target in B+1.
- Squashed ack in cycle A -> new request at target in A+1.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared definitions file: state encodings `FETCH_S_RESET`, `FETCH_S_REQ`, `FETCH_S_HOLD`; instruction width; word-address alignment constant.
- One sub-module: `branch_target_calc` (combinational sign-extend, shift, add: issued_pc, branch_offset -> target).

## Test plan
- Reset, RESET_PC=0x100, ack every request one cycle later, instr_ready=1 -> instr_pc sequence 0x100, 0x104, 0x108; first imem_req one cycle after reset release.
- Hold instr_ready=0 for 5 cycles in S_HOLD -> instr/instr_pc unchanged, imem_req=0 throughout; issue on 6th cycle.
- Issued pc 0x200, branch_taken with offset 0xFFFE in S_HOLD -> next imem_addr=0x1FC; held instruction never issued.
- branch_taken with offset 0x0010 while S_REQ waits 3 cycles for ack at 0x204 -> imem_addr held 0x204 until ack; data discarded; next request 0x244.
- pc=0xFFFFFFFC, issue -> next imem_addr=0x00000000 (wrap).
- Assert reset while S_REQ outstanding, then ack arrives -> ack ignored, all outputs at reset values, fetch restarts at RESET_PC.
